// File: rtl/fp_add_scheduler_if.sv
// fp_add_scheduler_if: requester, adder and status signals of the FP adder scheduler
interface fp_add_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 32
);
    logic hold;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0] req_ready;
    logic add_in_valid;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic add_out_valid;
    logic [DATA_W-1:0] add_result;
    logic [NUM_REQ-1:0] resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic busy;
    logic err;

    modport slave (
        input hold, req_valid, req_a, req_b, add_out_valid, add_result,
        output req_ready, add_in_valid, add_a, add_b, resp_valid, resp_data, busy, err
    );

    modport master (
        output hold, req_valid, req_a, req_b, add_out_valid, add_result,
        input req_ready, add_in_valid, add_a, add_b, resp_valid, resp_data, busy, err
    );
endinterface

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin sharing of one pipelined FP adder among NUM_REQ requesters
module fp_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 32,
    parameter int LAT = 3
) (
    input logic clk,
    input logic rst,
    fp_add_scheduler_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic found;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] outstanding;
    logic [NUM_REQ-1:0] out_nxt;
    logic [NUM_REQ-1:0] ret_mask;
    logic [LAT:0] tag_v;
    logic [IW-1:0] tag_id [LAT+1];
    logic retire;

    assign elig = bus.req_valid & ~outstanding & {NUM_REQ{~bus.hold & ~rst}};
    assign grant = found ? (NUM_REQ'(1) << win) : '0;
    assign retire = tag_v[LAT];
    assign ret_mask = retire ? (NUM_REQ'(1) << tag_id[LAT]) : '0;
    assign out_nxt = (outstanding & ~ret_mask) | grant;
    assign bus.req_ready = grant;

    // first eligible requester searching upward from ptr with wraparound
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k >= NUM_REQ) ? IW'(int'(ptr) + k - NUM_REQ) : IW'(int'(ptr) + k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    // issue, outstanding tracking, tag valid pipeline and retirement
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            outstanding <= '0;
            tag_v <= '0;
            bus.add_in_valid <= 1'b0;
            bus.add_a <= '0;
            bus.add_b <= '0;
            bus.resp_valid <= '0;
            bus.resp_data <= '0;
            bus.busy <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            bus.add_in_valid <= found;
            if (found) begin
                bus.add_a <= bus.req_a[int'(win)*DATA_W +: DATA_W];
                bus.add_b <= bus.req_b[int'(win)*DATA_W +: DATA_W];
                ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end
            outstanding <= out_nxt;
            bus.busy <= |out_nxt;
            tag_v <= {tag_v[LAT-1:0], found};
            bus.resp_valid <= bus.add_out_valid ? ret_mask : '0;
            if (retire && bus.add_out_valid)
                bus.resp_data <= bus.add_result;
            if (retire && !bus.add_out_valid)
                bus.err <= 1'b1;
        end
    end

    // requester ids travel alongside their valid bits; only the valid bits need reset
    always_ff @(posedge clk) begin
        tag_id[0] <= win;
        for (int k = 1; k <= LAT; k++)
            tag_id[k] <= tag_id[k-1];
    end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: randomized and directed checks of the FP adder scheduler against a behavioural model
module tb_fp_add_scheduler;
    localparam int N = 4;
    localparam int W = 32;
    localparam int LAT = 3;
    localparam int MAGIC = 777;

    typedef struct {
        int id;
        int due;
        logic drop;
        logic [W-1:0] sum;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_add_scheduler_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
    fp_add_scheduler #(.NUM_REQ(N), .DATA_W(W), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail = 0;

    // integer-valued IEEE single encode/decode for the bench adder and the model
    function automatic logic [31:0] encode(int v);
        int m = 0;
        if (v == 0) return 32'h0;
        for (int k = 0; k < 31; k++)
            if (((v >> k) & 1) != 0) m = k;
        return {1'b0, 8'(127 + m), 23'((v << (23 - m)) & 32'h7FFFFF)};
    endfunction

    function automatic int decode(logic [31:0] f);
        int e;
        if (f == 32'h0) return 0;
        e = int'(f[30:23]) - 127;
        return int'({9'b1, f[22:0]} >> (23 - e));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // bench adder: LAT-cycle pipeline that drops any operation whose operand A is MAGIC
    logic [LAT-1:0] pv = '0;
    logic [W-1:0] pd [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
        pv[0] <= bus.add_in_valid && decode(bus.add_a) != MAGIC;
        pd[0] <= encode(decode(bus.add_a) + decode(bus.add_b));
    end
    assign bus.add_out_valid = pv[LAT-1];
    assign bus.add_result = pd[LAT-1];

    // requester stimulus
    int ia [N];
    int ib [N];
    logic [N-1:0] want = '0;
    logic hold_i = 1'b0;
    logic one_shot = 1'b0;
    assign bus.req_valid = want;
    assign bus.hold = hold_i;
    always_comb begin
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = encode(ia[i]);
            bus.req_b[i*W +: W] = encode(ib[i]);
        end
    end

    // reference model state
    int m_ptr = 0;
    int cyc = 0;
    logic [N-1:0] m_out = '0;
    logic m_in_valid = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [N-1:0] m_resp_valid = '0;
    logic [W-1:0] m_resp_data = '0;
    logic m_err = 1'b0;
    op_t q [$];

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (want[i] && !m_out[i] && !hold_i && !rst) return i;
        end
        return -1;
    endfunction

    task automatic step();
        int w;
        logic rst_s;
        logic [N-1:0] one = 1;
        op_t op;
        @(negedge clk);
        w = winner();
        check("req_ready", bus.req_ready, (w >= 0) ? (one << w) : '0);
        check("add_in_valid", bus.add_in_valid, m_in_valid);
        check("add_a", bus.add_a, m_a);
        check("add_b", bus.add_b, m_b);
        check("resp_valid", bus.resp_valid, m_resp_valid);
        check("resp_data", bus.resp_data, m_resp_data);
        check("busy", bus.busy, |m_out);
        check("err", bus.err, m_err);
        @(posedge clk);
        rst_s = rst;
        if (rst_s) begin
            m_ptr = 0;
            m_out = '0;
            m_in_valid = 1'b0;
            m_a = '0;
            m_b = '0;
            m_resp_valid = '0;
            m_resp_data = '0;
            m_err = 1'b0;
            q.delete();
        end else begin
            m_resp_valid = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                op = q.pop_front();
                m_out[op.id] = 1'b0;
                if (op.drop) m_err = 1'b1;
                else begin
                    m_resp_valid = one << op.id;
                    m_resp_data = op.sum;
                end
            end
            m_in_valid = (w >= 0);
            if (w >= 0) begin
                m_a = encode(ia[w]);
                m_b = encode(ib[w]);
                m_out[w] = 1'b1;
                m_ptr = (w + 1) % N;
                q.push_back('{id: w, due: cyc + LAT + 1, drop: ia[w] == MAGIC, sum: encode(ia[w] + ib[w])});
            end
        end
        cyc++;
        #1;
        if (w >= 0) begin
            ia[w] = $urandom_range(1, 700);
            ib[w] = $urandom_range(1, 700);
            if (one_shot) want[w] = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ia[i] = $urandom_range(1, 700);
            ib[i] = $urandom_range(1, 700);
        end
        // reset with every requester asking: no grants may appear
        want = '1;
        steps(3);
        want = '0;
        rst = 1'b0;
        steps(2);

        // single operation from requester 1: 1.0 + 2.0
        one_shot = 1'b1;
        ia[1] = 1;
        ib[1] = 2;
        want = 4'b0010;
        steps(5);
        check("single_resp_valid", bus.resp_valid, 4'b0010);
        check("single_resp_data", bus.resp_data, 32'h40400000);
        steps(3);

        // all four requesters continuously
        one_shot = 1'b0;
        want = '1;
        steps(40);
        want = '0;
        steps(8);

        // move ptr to 3, then requesters 0 and 2 compete
        one_shot = 1'b1;
        want = 4'b0100;
        steps(8);
        one_shot = 1'b0;
        want = 4'b0101;
        steps(30);
        want = '0;
        steps(8);

        // two operations in flight, then hold for 6 cycles
        one_shot = 1'b1;
        want = 4'b0011;
        steps(2);
        one_shot = 1'b0;
        hold_i = 1'b1;
        want = '1;
        steps(6);
        hold_i = 1'b0;
        steps(10);
        want = '0;
        steps(8);

        // missing adder result for requester 3
        one_shot = 1'b1;
        ia[3] = MAGIC;
        want = 4'b1000;
        steps(7);
        check("err_sticky", bus.err, 1'b1);
        want = 4'b1000;
        steps(7);
        check("err_still_set", bus.err, 1'b1);

        // reset two cycles after a handshake; the stale result must be ignored
        want = 4'b0001;
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(6);
        check("rst_err_clear", bus.err, 1'b0);

        // random traffic with occasional hold and reset
        one_shot = 1'b0;
        for (int c = 0; c < 400; c++) begin
            want = N'($urandom);
            hold_i = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0;
        hold_i = 1'b0;
        want = '0;
        steps(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
